// File: rtl/camera_seq_pkg.sv
// rtl/camera_seq_pkg.sv - shared states, default timings and sizing helpers for the camera power sequencer
package camera_seq_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        PWDN_LOW,
        RST_WAIT,
        CONFIG,
        READY,
        FAIL
    } cam_state_e;

    // Default delays in clk_25M cycles
    localparam int unsigned DEF_T_PWDN_CYC      = 125000;
    localparam int unsigned DEF_T_RST_CYC       = 25000;
    localparam int unsigned DEF_T_INIT_CYC      = 500000;
    localparam int unsigned DEF_CFG_TIMEOUT_CYC = 50000000;
    localparam int unsigned DEF_MAX_RETRY       = 3;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Smallest width whose range 0 .. 2^w-1 holds max_cyc-1
    function automatic int unsigned timer_width(input int unsigned max_cyc);
        int unsigned     w;
        longint unsigned lim;
        w   = 1;
        lim = 2;
        while (lim < 64'(max_cyc)) begin
            w   = w + 1;
            lim = lim << 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/camera_power_seq.sv
// rtl/camera_power_seq.sv - OV5640 power-up, reset and configuration-wait sequencer with retry
module camera_power_seq
    import camera_seq_pkg::*;
#(
    parameter  int unsigned T_PWDN_CYC      = DEF_T_PWDN_CYC,
    parameter  int unsigned T_RST_CYC       = DEF_T_RST_CYC,
    parameter  int unsigned T_INIT_CYC      = DEF_T_INIT_CYC,
    parameter  int unsigned CFG_TIMEOUT_CYC = DEF_CFG_TIMEOUT_CYC,
    parameter  int unsigned MAX_RETRY       = DEF_MAX_RETRY,
    localparam int unsigned RETRY_W         = $clog2(MAX_RETRY + 1)
) (
    input  logic               clk_25M,
    input  logic               sys_rstn,
    input  logic               restart,
    input  logic               reg_conf_done,
    output logic               camera_pwdn,
    output logic               camera_rstn,
    output logic               initial_en,
    output logic               cam_ready,
    output logic               cam_fail,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int unsigned TMR_W = timer_width(max4(T_PWDN_CYC, T_RST_CYC,
                                                     T_INIT_CYC, CFG_TIMEOUT_CYC));

    cam_state_e         state;
    cam_state_e         nxt;
    logic [TMR_W-1:0]   timer;
    logic [RETRY_W-1:0] retry_nxt;
    logic               enter;
    logic               done_s;

    sync_2ff u_done_sync (
        .clk    (clk_25M),
        .resetn (sys_rstn),
        .d      (reg_conf_done),
        .q      (done_s)
    );

    // A lost done in READY is handled exactly like a CONFIG timeout
    always_comb begin
        nxt       = state;
        retry_nxt = retry_cnt;
        if (restart) begin
            nxt       = PWR_WAIT;
            retry_nxt = '0;
        end else begin
            case (state)
                PWR_WAIT: if (timer == TMR_W'(T_PWDN_CYC - 1)) nxt = PWDN_LOW;
                PWDN_LOW: if (timer == TMR_W'(T_RST_CYC - 1))  nxt = RST_WAIT;
                RST_WAIT: if (timer == TMR_W'(T_INIT_CYC - 1)) nxt = CONFIG;
                CONFIG, READY: begin
                    if (state == CONFIG && done_s) begin
                        nxt = READY;
                    end else if ((state == CONFIG && timer == TMR_W'(CFG_TIMEOUT_CYC - 1)) ||
                                 (state == READY && !done_s)) begin
                        if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                            nxt       = PWR_WAIT;
                            retry_nxt = retry_cnt + RETRY_W'(1);
                        end else begin
                            nxt = FAIL;
                        end
                    end
                end
                FAIL:    nxt = FAIL;
                default: nxt = PWR_WAIT;
            endcase
        end
        enter = restart || (nxt != state);
    end

    always_ff @(posedge clk_25M) begin
        if (!sys_rstn) begin
            state       <= PWR_WAIT;
            timer       <= '0;
            retry_cnt   <= '0;
            camera_pwdn <= 1'b1;
            camera_rstn <= 1'b0;
            initial_en  <= 1'b0;
            cam_ready   <= 1'b0;
            cam_fail    <= 1'b0;
        end else begin
            state       <= nxt;
            timer       <= enter ? '0 : timer + TMR_W'(1);
            retry_cnt   <= retry_nxt;
            camera_pwdn <= (nxt == PWR_WAIT) || (nxt == FAIL);
            camera_rstn <= (nxt == RST_WAIT) || (nxt == CONFIG) || (nxt == READY);
            initial_en  <= (nxt == CONFIG);
            cam_ready   <= (nxt == READY);
            cam_fail    <= (nxt == FAIL);
        end
    end

endmodule

// File: tb/tb_camera_power_seq.sv
// tb/tb_camera_power_seq.sv - scoreboard bench for camera_power_seq output transitions
module tb_camera_power_seq;

    localparam logic [4:0] S_PWR  = 5'b10000;
    localparam logic [4:0] S_PDL  = 5'b00000;
    localparam logic [4:0] S_RST  = 5'b01000;
    localparam logic [4:0] S_CFG  = 5'b01100;
    localparam logic [4:0] S_RDY  = 5'b01010;
    localparam logic [4:0] S_FAIL = 5'b10001;

    typedef struct {
        int         cyc;
        logic [6:0] v;
    } exp_t;

    logic       clk_25M = 1'b0;
    logic       sys_rstn = 1'b0;
    logic       restart = 1'b0;
    logic       reg_conf_done = 1'b0;
    logic       camera_pwdn, camera_rstn, initial_en, cam_ready, cam_fail;
    logic [1:0] retry_cnt;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    logic [6:0] prev = 'x;

    camera_power_seq #(
        .T_PWDN_CYC      (10),
        .T_RST_CYC       (5),
        .T_INIT_CYC      (20),
        .CFG_TIMEOUT_CYC (100),
        .MAX_RETRY       (2)
    ) dut (
        .clk_25M       (clk_25M),
        .sys_rstn      (sys_rstn),
        .restart       (restart),
        .reg_conf_done (reg_conf_done),
        .camera_pwdn   (camera_pwdn),
        .camera_rstn   (camera_rstn),
        .initial_en    (initial_en),
        .cam_ready     (cam_ready),
        .cam_fail      (cam_fail),
        .retry_cnt     (retry_cnt)
    );

    always #20 clk_25M = ~clk_25M;

    always @(posedge clk_25M) cyc <= cyc + 1;

    function automatic logic [6:0] ev(input logic [4:0] o, input int r);
        return {o, 2'(r)};
    endfunction

    task automatic push(input int c, input logic [6:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic nominal(input int b, input int r);
        push(b + 10, ev(S_PDL, r));
        push(b + 15, ev(S_RST, r));
        push(b + 35, ev(S_CFG, r));
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk_25M);
    endtask

    // Monitor: every change of the output vector must match the next expected event
    always @(posedge clk_25M) begin
        logic [6:0] cur;
        exp_t       e;
        #1;
        if (mon_en) begin
            cur = {camera_pwdn, camera_rstn, initial_en, cam_ready, cam_fail, retry_cnt};
            if (cur !== prev) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: cycle %0d outputs %b, required no change", cyc, cur);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e.v || (e.cyc >= 0 && e.cyc != cyc)) begin
                        n_bad++;
                        $display("FAIL out_event: cycle %0d outputs %b, required cycle %0d outputs %b",
                                 cyc, cur, e.cyc, e.v);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        int b;
        repeat (3) @(negedge clk_25M);
        push(-1, ev(S_PWR, 0));
        mon_en = 1'b1;
        @(negedge clk_25M);

        // Nominal bring-up, done 30 cycles after initial_en
        b = cyc;
        sys_rstn = 1'b1;
        nominal(b, 0);
        push(b + 67, ev(S_RDY, 0));
        wait_cyc(b + 64);
        reg_conf_done = 1'b1;

        // Lose done in READY: retry 1 and full re-sequence
        push(b + 83, ev(S_PWR, 1));
        wait_cyc(b + 80);
        reg_conf_done = 1'b0;
        b = b + 83;
        nominal(b, 1);

        // done_s arrives exactly as the CONFIG timer hits its last count
        push(b + 135, ev(S_RDY, 1));
        wait_cyc(b + 132);
        reg_conf_done = 1'b1;

        // Restart from READY, then let every attempt time out
        wait_cyc(b + 150);
        push(b + 151, ev(S_PWR, 0));
        restart = 1'b1;
        reg_conf_done = 1'b0;
        @(negedge clk_25M);
        restart = 1'b0;
        b = b + 151;
        nominal(b, 0);
        push(b + 135, ev(S_PWR, 1));
        nominal(b + 135, 1);
        push(b + 270, ev(S_PWR, 2));
        nominal(b + 270, 2);
        push(b + 405, ev(S_FAIL, 2));

        // FAIL holds; then restart out of FAIL
        wait_cyc(b + 450);
        push(b + 451, ev(S_PWR, 0));
        restart = 1'b1;
        @(negedge clk_25M);
        restart = 1'b0;
        b = b + 451;
        nominal(b, 0);

        // One-cycle sys_rstn pulse in CONFIG
        wait_cyc(b + 50);
        push(b + 51, ev(S_PWR, 0));
        sys_rstn = 1'b0;
        @(negedge clk_25M);
        sys_rstn = 1'b1;
        b = b + 51;
        nominal(b, 0);
        wait_cyc(b + 45);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: %0d expected events never seen, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
